// File: rtl/rvfi_order_buffer_pkg.sv
// Shared types for the RVFI order buffer: the retirement record layout
// carried from writeback to the RVFI channel, plus ring-index helpers.
package rvfi_order_buffer_pkg;

  localparam int RVFI_XLEN = 32;

  typedef struct packed {
    logic [31:0]          insn;
    logic                 trap;
    logic [4:0]           rs1_addr;
    logic [4:0]           rs2_addr;
    logic [RVFI_XLEN-1:0] rs1_rdata;
    logic [RVFI_XLEN-1:0] rs2_rdata;
    logic [4:0]           rd_addr;
    logic [RVFI_XLEN-1:0] rd_wdata;
    logic [RVFI_XLEN-1:0] pc_rdata;
    logic [RVFI_XLEN-1:0] pc_wdata;
  } rvfi_rec_t;

  localparam int REC_W = $bits(rvfi_rec_t);

  // Distance of a slot from the head slot, modulo a power-of-two ring size.
  function automatic int unsigned slot_offset(int unsigned tag, int unsigned head,
                                              int unsigned depth);
    return (tag - head) & (depth - 1);
  endfunction

  function automatic logic slot_in_window(int unsigned tag, int unsigned head,
                                          int unsigned count, int unsigned depth);
    return slot_offset(tag, head, depth) < count;
  endfunction

endpackage

// File: rtl/rvfi_order_buffer_mem.sv
// Record storage for the order buffer: one synchronous write port fed by
// writeback and one combinational read port addressed by the head slot.
module rvfi_order_buffer_mem
  import rvfi_order_buffer_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int IDXW = $clog2(DEPTH)
) (
  input  logic            clock,
  input  logic            we,
  input  logic [IDXW-1:0] waddr,
  input  rvfi_rec_t       wdata,
  input  logic [IDXW-1:0] raddr,
  output rvfi_rec_t       rdata
);

  rvfi_rec_t mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rvfi_order_buffer.sv
// Reorders out-of-order writeback records into program order on one RVFI channel.
// Define RVFI_ORDER_BUFFER_X0_EN to force x0 read/write data to zero at emit.
module rvfi_order_buffer
  import rvfi_order_buffer_pkg::*;
#(
  parameter int XLEN  = RVFI_XLEN,
  parameter int DEPTH = 8,
  localparam int IDXW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             flush,
  input  logic             alloc_valid,
  output logic             alloc_ready,
  output logic [IDXW-1:0]  alloc_tag,
  input  logic             wb_valid,
  input  logic [IDXW-1:0]  wb_tag,
  input  logic [REC_W-1:0] wb_rec,
  output logic             rvfi_valid,
  output logic [63:0]      rvfi_order,
  output logic [31:0]      rvfi_insn,
  output logic             rvfi_trap,
  output logic [4:0]       rvfi_rs1_addr,
  output logic [4:0]       rvfi_rs2_addr,
  output logic [XLEN-1:0]  rvfi_rs1_rdata,
  output logic [XLEN-1:0]  rvfi_rs2_rdata,
  output logic [4:0]       rvfi_rd_addr,
  output logic [XLEN-1:0]  rvfi_rd_wdata,
  output logic [XLEN-1:0]  rvfi_pc_rdata,
  output logic [XLEN-1:0]  rvfi_pc_wdata,
  output logic             err_sticky
);

  logic [IDXW:0]    head, tail, count;
  logic [IDXW-1:0]  head_idx;
  logic [DEPTH-1:0] done, done_next;
  logic [63:0]      order_cnt;
  logic             alloc_fire, wb_hit, wb_ok, wb_err, emit;
  rvfi_rec_t        wb_data, head_rec, emit_rec, out_rec;

  assign wb_data  = wb_rec;
  assign count    = tail - head;
  assign head_idx = head[IDXW-1:0];

  // Gated by resetn so the port reads 0 while the buffer is held in reset.
  assign alloc_ready = resetn && (count < (IDXW+1)'(DEPTH)) && !flush;
  assign alloc_tag   = tail[IDXW-1:0];
  assign alloc_fire  = alloc_valid && alloc_ready;

  assign wb_hit = slot_in_window(32'(wb_tag), 32'(head_idx), 32'(count), 32'(DEPTH))
                  && !done[wb_tag];
  assign wb_ok  = wb_valid && !flush && wb_hit;
  assign wb_err = wb_valid && !flush && !wb_hit;
  assign emit   = (count != '0) && done[head_idx] && !flush;

  rvfi_order_buffer_mem #(.DEPTH(DEPTH)) u_mem (
    .clock (clock),
    .we    (wb_ok),
    .waddr (wb_tag),
    .wdata (wb_data),
    .raddr (head_idx),
    .rdata (head_rec)
  );

  // The three slot updates never target the same index in one cycle.
  always_comb begin
    done_next = done;
    if (alloc_fire) done_next[alloc_tag] = 1'b0;
    if (wb_ok)      done_next[wb_tag]    = 1'b1;
    if (emit)       done_next[head_idx]  = 1'b0;
  end

  always_comb begin
    emit_rec = head_rec;
`ifdef RVFI_ORDER_BUFFER_X0_EN
    if (head_rec.rd_addr == 5'd0)  emit_rec.rd_wdata  = '0;
    if (head_rec.rs1_addr == 5'd0) emit_rec.rs1_rdata = '0;
    if (head_rec.rs2_addr == 5'd0) emit_rec.rs2_rdata = '0;
`endif
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      head      <= '0;
      tail      <= '0;
      done      <= '0;
      order_cnt <= '0;
    end else if (flush) begin
      head <= tail;
      done <= '0;
    end else begin
      if (alloc_fire) tail <= tail + 1'b1;
      if (emit) begin
        head      <= head + 1'b1;
        order_cnt <= order_cnt + 64'd1;
      end
      done <= done_next;
    end
  end

  // Output fields hold their last emitted record while rvfi_valid is low.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rvfi_valid <= 1'b0;
      rvfi_order <= '0;
      out_rec    <= '0;
      err_sticky <= 1'b0;
    end else begin
      rvfi_valid <= emit;
      if (emit) begin
        out_rec    <= emit_rec;
        rvfi_order <= order_cnt;
      end
      if (wb_err) err_sticky <= 1'b1;
    end
  end

  assign rvfi_insn      = out_rec.insn;
  assign rvfi_trap      = out_rec.trap;
  assign rvfi_rs1_addr  = out_rec.rs1_addr;
  assign rvfi_rs2_addr  = out_rec.rs2_addr;
  assign rvfi_rs1_rdata = out_rec.rs1_rdata;
  assign rvfi_rs2_rdata = out_rec.rs2_rdata;
  assign rvfi_rd_addr   = out_rec.rd_addr;
  assign rvfi_rd_wdata  = out_rec.rd_wdata;
  assign rvfi_pc_rdata  = out_rec.pc_rdata;
  assign rvfi_pc_wdata  = out_rec.pc_wdata;

endmodule

// File: tb/tb_rvfi_order_buffer.sv
// Self-checking bench for rvfi_order_buffer: a queue-based program-order model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_rvfi_order_buffer;
  import rvfi_order_buffer_pkg::*;

  localparam int DEPTH = 8;
  localparam int IDXW  = 3;

  logic            clock, resetn, flush, alloc_valid, alloc_ready, wb_valid;
  logic [IDXW-1:0] alloc_tag, wb_tag;
  rvfi_rec_t       wb_rec;
  logic            rvfi_valid, rvfi_trap, err_sticky;
  logic [63:0]     rvfi_order;
  logic [31:0]     rvfi_insn, rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata;
  logic [31:0]     rvfi_pc_rdata, rvfi_pc_wdata;
  logic [4:0]      rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
  rvfi_rec_t       act_rec;

  rvfi_order_buffer #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .clock(clock), .resetn(resetn), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_rec(wb_rec),
    .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
    .rvfi_trap(rvfi_trap), .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
    .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
    .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
    .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
    .err_sticky(err_sticky)
  );

  assign act_rec = {rvfi_insn, rvfi_trap, rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rs1_rdata,
                    rvfi_rs2_rdata, rvfi_rd_addr, rvfi_rd_wdata, rvfi_pc_rdata, rvfi_pc_wdata};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference model: in-flight tags in program order, completion flags and records.
  int unsigned     q_tags[$];
  bit              m_done [DEPTH];
  rvfi_rec_t       m_rec  [DEPTH];
  int unsigned     next_tag;
  longint unsigned m_order;
  bit              exp_valid, exp_err;
  logic [63:0]     exp_order;
  rvfi_rec_t       exp_rec;
  int              checks, failures, cyc;

  typedef struct {
    int              cyc;
    longint unsigned order;
    logic [31:0]     pc;
  } emit_t;
  emit_t log_q[$];

  always @(posedge clock) cyc = cyc + 1;

  function automatic void check_output(input string name, input logic [255:0] act,
                                       input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  function automatic rvfi_rec_t x0_mask(input rvfi_rec_t r);
    rvfi_rec_t m;
    m = r;
`ifdef RVFI_ORDER_BUFFER_X0_EN
    if (m.rd_addr == 5'd0)  m.rd_wdata  = 32'h0;
    if (m.rs1_addr == 5'd0) m.rs1_rdata = 32'h0;
    if (m.rs2_addr == 5'd0) m.rs2_rdata = 32'h0;
`endif
    return m;
  endfunction

  function automatic bit in_flight(input int unsigned tag);
    foreach (q_tags[i]) if (q_tags[i] == tag) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_reset();
    q_tags.delete();
    foreach (m_done[i]) m_done[i] = 1'b0;
    next_tag  = 0;
    m_order   = 0;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    exp_order = '0;
    exp_rec   = '0;
    log_q.delete();
  endfunction

  function automatic void model_step(input bit av, input bit wv, input int unsigned wt,
                                     input rvfi_rec_t r, input bit fl);
    bit ready, emit, wb_legal;
    ready = (q_tags.size() < DEPTH) && !fl;
    if (fl) begin
      q_tags.delete();
      foreach (m_done[i]) m_done[i] = 1'b0;
      exp_valid = 1'b0;
      return;
    end
    emit     = (q_tags.size() > 0) && m_done[q_tags[0]];
    wb_legal = wv && in_flight(wt) && !m_done[wt];
    if (wv && !wb_legal) exp_err = 1'b1;
    exp_valid = emit;
    if (emit) begin
      exp_rec   = x0_mask(m_rec[q_tags[0]]);
      exp_order = m_order;
      m_order++;
      m_done[q_tags[0]] = 1'b0;
      void'(q_tags.pop_front());
    end
    if (wb_legal) begin
      m_done[wt] = 1'b1;
      m_rec[wt]  = r;
    end
    if (av && ready) begin
      m_done[next_tag] = 1'b0;
      q_tags.push_back(next_tag);
      next_tag = (next_tag + 1) % DEPTH;
    end
  endfunction

  // Compare process: combinational outputs just before each edge, registered ones just after.
  initial begin : compare
    bit av, wv, fl;
    int unsigned wt;
    rvfi_rec_t r;
    forever begin
      @(negedge clock);
      #3;
      if (resetn) begin
        av = alloc_valid; wv = wb_valid; fl = flush; wt = 32'(wb_tag); r = wb_rec;
        check_output("alloc_ready", 256'(alloc_ready), 256'((q_tags.size() < DEPTH) && !fl));
        check_output("alloc_tag", 256'(alloc_tag), 256'(next_tag));
        @(posedge clock);
        model_step(av, wv, wt, r, fl);
        #1;
        check_output("rvfi_valid", 256'(rvfi_valid), 256'(exp_valid));
        check_output("rvfi_order", 256'(rvfi_order), 256'(exp_order));
        check_output("rvfi_rec", 256'(act_rec), 256'(exp_rec));
        check_output("err_sticky", 256'(err_sticky), 256'(exp_err));
        if (rvfi_valid) log_q.push_back('{cyc, rvfi_order, rvfi_pc_rdata});
      end
    end
  end

  function automatic rvfi_rec_t make_rec(input logic [31:0] pc);
    rvfi_rec_t r;
    r.insn      = $urandom;
    r.trap      = 1'($urandom);
    r.rs1_addr  = 5'($urandom);
    r.rs2_addr  = 5'($urandom);
    r.rs1_rdata = $urandom;
    r.rs2_rdata = $urandom;
    r.rd_addr   = 5'($urandom);
    r.rd_wdata  = $urandom;
    r.pc_rdata  = pc;
    r.pc_wdata  = pc + 32'd4;
    return r;
  endfunction

  // Drives one cycle of inputs starting at a falling edge.
  task automatic apply_stimulus(input bit av, input bit wv, input int unsigned wt,
                                input rvfi_rec_t r, input bit fl);
    alloc_valid = av;
    wb_valid    = wv;
    wb_tag      = IDXW'(wt);
    wb_rec      = r;
    flush       = fl;
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    repeat (n) apply_stimulus(1'b0, 1'b0, 0, '0, 1'b0);
  endtask

  // Asserts reset mid-cycle so the asynchronous clear is observed between edges.
  task automatic do_reset();
    alloc_valid = 1'b0; wb_valid = 1'b0; flush = 1'b0; wb_tag = '0; wb_rec = '0;
    #2 resetn = 1'b0;
    #1;
    check_output("reset_rvfi_valid", 256'(rvfi_valid), 256'(0));
    check_output("reset_rvfi_order", 256'(rvfi_order), 256'(0));
    check_output("reset_rvfi_rec", 256'(act_rec), 256'(0));
    check_output("reset_alloc_ready", 256'(alloc_ready), 256'(0));
    check_output("reset_alloc_tag", 256'(alloc_tag), 256'(0));
    check_output("reset_err_sticky", 256'(err_sticky), 256'(0));
    model_reset();
    @(negedge clock);
    resetn = 1'b1;
    #1 check_output("ready_after_reset", 256'(alloc_ready), 256'(1));
  endtask

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin : stimulus
    int k0;
    logic [31:0] exp_wd;
    rvfi_rec_t r;
    checks = 0; failures = 0; cyc = 0;
    resetn = 1'b0; flush = 1'b0; alloc_valid = 1'b0; wb_valid = 1'b0;
    wb_tag = '0; wb_rec = '0;
    model_reset();
    @(negedge clock);
    do_reset();

    // Out-of-order completion of three slots retires in program order.
    repeat (3) apply_stimulus(1'b1, 1'b0, 0, '0, 1'b0);
    apply_stimulus(1'b0, 1'b1, 2, make_rec(32'd2), 1'b0);
    apply_stimulus(1'b0, 1'b1, 1, make_rec(32'd1), 1'b0);
    k0 = cyc + 1;
    apply_stimulus(1'b0, 1'b1, 0, make_rec(32'd0), 1'b0);
    idle(4);
    check_output("inorder_count", 256'(log_q.size()), 256'(3));
    for (int i = 0; i < 3 && i < log_q.size(); i++) begin
      check_output("inorder_order", 256'(log_q[i].order), 256'(i));
      check_output("inorder_pc", 256'(log_q[i].pc), 256'(i));
    end
    if (log_q.size() == 3) begin
      check_output("wb_to_valid_latency", 256'(log_q[0].cyc), 256'(k0 + 1));
      check_output("back_to_back", 256'(log_q[2].cyc), 256'(k0 + 3));
    end

    // Full buffer, re-grant of tag 0, then random traffic across many wraps.
    do_reset();
    repeat (DEPTH) apply_stimulus(1'b1, 1'b0, 0, '0, 1'b0);
    check_output("full_not_ready", 256'(alloc_ready), 256'(0));
    apply_stimulus(1'b0, 1'b1, 0, make_rec(32'h40), 1'b0);
    check_output("full_while_emitting", 256'(alloc_ready), 256'(0));
    idle(1);
    check_output("ready_after_emit", 256'(alloc_ready), 256'(1));
    check_output("regrant_tag0", 256'(alloc_tag), 256'(0));
    check_output("tag0_emitted", 256'(rvfi_valid), 256'(1));
    for (int n = 0; n < 600; n++) begin
      int unsigned pend[$];
      bit fl, av, wv;
      int unsigned wt;
      foreach (q_tags[i]) if (!m_done[q_tags[i]]) pend.push_back(q_tags[i]);
      fl = ($urandom_range(0, 59) == 0);
      av = ($urandom_range(0, 3) != 0);
      wv = !fl && (pend.size() != 0) && ($urandom_range(0, 3) != 0);
      wt = wv ? pend[$urandom_range(0, pend.size() - 1)] : 0;
      apply_stimulus(av, wv, wt, make_rec(32'(n) + 32'h1000), fl);
    end
    idle(4);
    check_output("wrap_min_records", 256'(log_q.size() >= 3 * DEPTH), 256'(1));
    foreach (log_q[i]) check_output("wrap_contiguous", 256'(log_q[i].order), 256'(i));

    // Flush discards pending slots but keeps the order count running.
    do_reset();
    repeat (4) apply_stimulus(1'b1, 1'b0, 0, '0, 1'b0);
    apply_stimulus(1'b0, 1'b1, 0, make_rec(32'h10), 1'b0);
    apply_stimulus(1'b0, 1'b1, 1, make_rec(32'h11), 1'b0);
    idle(2);
    apply_stimulus(1'b0, 1'b0, 0, '0, 1'b1);
    check_output("flush_next_tag", 256'(alloc_tag), 256'(4));
    idle(3);
    check_output("flush_emitted", 256'(log_q.size()), 256'(2));
    apply_stimulus(1'b1, 1'b0, 0, '0, 1'b0);
    apply_stimulus(1'b0, 1'b1, 4, make_rec(32'h14), 1'b0);
    idle(3);
    check_output("post_flush_count", 256'(log_q.size()), 256'(3));
    if (log_q.size() == 3) begin
      check_output("post_flush_order", 256'(log_q[2].order), 256'(2));
      check_output("post_flush_pc", 256'(log_q[2].pc), 256'(32'h14));
    end

    // Illegal writebacks: unallocated tag, then a second write to a done slot.
    do_reset();
    apply_stimulus(1'b0, 1'b1, 5, make_rec(32'h99), 1'b0);
    check_output("err_unalloc", 256'(err_sticky), 256'(1));
    idle(2);
    check_output("err_unalloc_no_emit", 256'(log_q.size()), 256'(0));
    do_reset();
    repeat (2) apply_stimulus(1'b1, 1'b0, 0, '0, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1, make_rec(32'hA1), 1'b0);
    check_output("err_clear_after_legal", 256'(err_sticky), 256'(0));
    apply_stimulus(1'b0, 1'b1, 1, make_rec(32'hB2), 1'b0);
    check_output("err_double_wb", 256'(err_sticky), 256'(1));
    apply_stimulus(1'b0, 1'b1, 0, make_rec(32'hA0), 1'b0);
    idle(3);
    check_output("err_emit_count", 256'(log_q.size()), 256'(2));
    if (log_q.size() == 2) check_output("err_record_kept", 256'(log_q[1].pc), 256'(32'hA1));

    // x0 destination data handling.
    do_reset();
    r = make_rec(32'h50);
    r.rd_addr  = 5'd0;
    r.rd_wdata = 32'hDEADBEEF;
    apply_stimulus(1'b1, 1'b0, 0, '0, 1'b0);
    apply_stimulus(1'b0, 1'b1, 0, r, 1'b0);
    idle(2);
`ifdef RVFI_ORDER_BUFFER_X0_EN
    exp_wd = 32'h0;
`else
    exp_wd = 32'hDEADBEEF;
`endif
    check_output("x0_rd_wdata", 256'(rvfi_rd_wdata), 256'(exp_wd));
    check_output("x0_pc", 256'(rvfi_pc_rdata), 256'(32'h50));

    // Reset with five slots pending, then the order count restarts at 0.
    repeat (5) apply_stimulus(1'b1, 1'b0, 0, '0, 1'b0);
    apply_stimulus(1'b0, 1'b1, 2, make_rec(32'h62), 1'b0);
    apply_stimulus(1'b0, 1'b1, 3, make_rec(32'h63), 1'b0);
    do_reset();
    apply_stimulus(1'b1, 1'b0, 0, '0, 1'b0);
    apply_stimulus(1'b0, 1'b1, 0, make_rec(32'h60), 1'b0);
    idle(3);
    check_output("after_reset_count", 256'(log_q.size()), 256'(1));
    if (log_q.size() == 1) begin
      check_output("after_reset_order", 256'(log_q[0].order), 256'(0));
      check_output("after_reset_pc", 256'(log_q[0].pc), 256'(32'h60));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
